// File: rtl/hazard_unit_mc.sv
// hazard_unit_mc
// Hazard unit for the 5-stage RISC-V core. It provides:
//   - EX-stage operand forwarding from MEM and WB
//   - load-use interlock
//   - branch/jump redirect flush
//   - occupancy tracking for multi-cycle mul/div ops held in EX
//   - a data-memory wait freeze
// It drives the pipeline-register enables and flushes directly.
//
// Ports:
//   clk, rst                   core clock, synchronous active-high reset
//   rs1_d/rs2_d, use_rs*_d     decode-stage sources and their use flags
//   rs1_e/rs2_e/rd_e           EX-stage register indices
//   ld_e, mdu_e, pc_sel_e      EX is a load / mul-div / taken redirect
//   rd_m/rd_w, regwrite_m/_w   MEM and WB destinations and write enables
//   dmem_req_m, dmem_ready     data-memory handshake
//   fwd_a_e/fwd_b_e            operand select: 00 regfile, 10 MEM, 01 WB
//   en_f/en_d/en_e/en_m        pipeline-register advance enables
//   flush_d/flush_e/flush_m    bubble inserts
//   mdu_busy, mdu_done         MDU occupancy and final-cycle pulse
//
// MDU FSM states:
//   state | meaning
//   IDLE  | no MDU op in EX (an op arriving now starts occupancy this cycle)
//   BUSY  | MDU op occupying EX; cnt_q = occupancy cycles left after this one
//
// The entry cycle counts as the first occupancy cycle, so it is treated as
// carrying cnt = MDU_LAT-1 and the stored count after entry is MDU_LAT-2.
// This gives exactly MDU_LAT cycles in EX and MDU_LAT-1 bubbles into MEM.
// MDU_LAT must be in 2..16 and fit in CNT_W bits.

module hazard_unit_mc #(
  parameter int REG_AW  = 5,
  parameter int MDU_LAT = 4,
  parameter int CNT_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] rs1_d,
  input  logic [REG_AW-1:0] rs2_d,
  input  logic              use_rs1_d,
  input  logic              use_rs2_d,
  input  logic [REG_AW-1:0] rs1_e,
  input  logic [REG_AW-1:0] rs2_e,
  input  logic [REG_AW-1:0] rd_e,
  input  logic              ld_e,
  input  logic              mdu_e,
  input  logic              pc_sel_e,
  input  logic [REG_AW-1:0] rd_m,
  input  logic [REG_AW-1:0] rd_w,
  input  logic              regwrite_m,
  input  logic              regwrite_w,
  input  logic              dmem_req_m,
  input  logic              dmem_ready,
  output logic [1:0]        fwd_a_e,
  output logic [1:0]        fwd_b_e,
  output logic              en_f,
  output logic              en_d,
  output logic              en_e,
  output logic              en_m,
  output logic              flush_d,
  output logic              flush_e,
  output logic              flush_m,
  output logic              mdu_busy,
  output logic              mdu_done
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mdu_state_t;

  localparam logic [CNT_W-1:0] CNT_ENTRY = CNT_W'(MDU_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(MDU_LAT - 2);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  mdu_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             memwait;
  logic             lwstall;
  logic             mdu_enter;
  logic             in_op;
  logic [CNT_W-1:0] cnt_cur;
  logic             mduhold;

  // ---------------------------------------------------------------------
  // Hazard conditions
  // ---------------------------------------------------------------------
  always_comb begin
    memwait = dmem_req_m && !dmem_ready;

    lwstall = ld_e && (rd_e != '0) &&
              ((use_rs1_d && (rs1_d == rd_e)) ||
               (use_rs2_d && (rs2_d == rd_e)));

    // An op arriving while memory is stalled waits; it enters on the
    // first non-stalled cycle instead.
    mdu_enter = (state_q == IDLE) && mdu_e && !memwait;
    in_op     = (state_q == BUSY) || mdu_enter;
    cnt_cur   = mdu_enter ? CNT_ENTRY : cnt_q;
    mduhold   = in_op && (cnt_cur != '0);
  end

  // ---------------------------------------------------------------------
  // MDU FSM: next state
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    // memwait freezes both state and count.
    if (!memwait) begin
      case (state_q)
        IDLE: begin
          if (mdu_e) begin
            state_d = BUSY;
            cnt_d   = CNT_LOAD;
          end
        end
        BUSY: begin
          if (cnt_q == '0) begin
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------
  // Forwarding: MEM has priority over WB, x0 never forwarded, not gated
  // by stalls.
  // ---------------------------------------------------------------------
  always_comb begin
    fwd_a_e = 2'b00;
    fwd_b_e = 2'b00;
    if (!rst) begin
      if (regwrite_m && (rd_m == rs1_e) && (rs1_e != '0)) begin
        fwd_a_e = 2'b10;
      end else if (regwrite_w && (rd_w == rs1_e) && (rs1_e != '0)) begin
        fwd_a_e = 2'b01;
      end

      if (regwrite_m && (rd_m == rs2_e) && (rs2_e != '0)) begin
        fwd_b_e = 2'b10;
      end else if (regwrite_w && (rd_w == rs2_e) && (rs2_e != '0)) begin
        fwd_b_e = 2'b01;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Pipeline control, highest priority first
  // ---------------------------------------------------------------------
  always_comb begin
    en_f     = 1'b1;
    en_d     = 1'b1;
    en_e     = 1'b1;
    en_m     = 1'b1;
    flush_d  = 1'b0;
    flush_e  = 1'b0;
    flush_m  = 1'b0;
    mdu_busy = 1'b0;
    mdu_done = 1'b0;

    if (rst) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
      flush_m = 1'b1;
    end else begin
      mdu_busy = in_op;
      // The final occupancy cycle only counts once memory lets it advance.
      mdu_done = in_op && (cnt_cur == '0) && !memwait;

      if (memwait) begin
        en_f = 1'b0;
        en_d = 1'b0;
        en_e = 1'b0;
        en_m = 1'b0;
      end else if (mduhold) begin
        // Hold F/D/E on the MDU op; MEM keeps draining and gets a bubble.
        en_f    = 1'b0;
        en_d    = 1'b0;
        en_e    = 1'b0;
        flush_m = 1'b1;
      end else if (pc_sel_e) begin
        // Redirect wins over a load-use stall: the younger op is squashed.
        flush_d = 1'b1;
        flush_e = 1'b1;
      end else if (lwstall) begin
        en_f    = 1'b0;
        en_d    = 1'b0;
        flush_e = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_unit_mc.sv
module tb_hazard_unit_mc;

  localparam int REG_AW  = 5;
  localparam int MDU_LAT = 4;
  localparam int CNT_W   = 4;

  logic              clk;
  logic              rst;
  logic [REG_AW-1:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic              use_rs1_d, use_rs2_d, ld_e, mdu_e, pc_sel_e;
  logic              regwrite_m, regwrite_w, dmem_req_m, dmem_ready;
  logic [1:0]        fwd_a_e, fwd_b_e;
  logic              en_f, en_d, en_e, en_m;
  logic              flush_d, flush_e, flush_m, mdu_busy, mdu_done;

  int checks = 0;
  int errors = 0;

  hazard_unit_mc #(.REG_AW(REG_AW), .MDU_LAT(MDU_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .use_rs1_d(use_rs1_d), .use_rs2_d(use_rs2_d),
    .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
    .ld_e(ld_e), .mdu_e(mdu_e), .pc_sel_e(pc_sel_e),
    .rd_m(rd_m), .rd_w(rd_w), .regwrite_m(regwrite_m), .regwrite_w(regwrite_w),
    .dmem_req_m(dmem_req_m), .dmem_ready(dmem_ready),
    .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e),
    .en_f(en_f), .en_d(en_d), .en_e(en_e), .en_m(en_m),
    .flush_d(flush_d), .flush_e(flush_e), .flush_m(flush_m),
    .mdu_busy(mdu_busy), .mdu_done(mdu_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output vector: {fwd_a, fwd_b, en_f, en_d, en_e, en_m, fl_d, fl_e, fl_m, busy, done}
  localparam logic [3:0] EN_ALL  = 4'b1111;
  localparam logic [3:0] EN_NONE = 4'b0000;
  localparam logic [3:0] EN_HOLD = 4'b0001;
  localparam logic [3:0] EN_LW   = 4'b0011;

  function automatic logic [14:0] ov(logic [1:0] fa, logic [1:0] fb, logic [3:0] en,
                                     logic [2:0] fl, logic busy, logic done);
    return {fa, fb, en, fl, busy, done};
  endfunction

  task automatic check(string name, logic [14:0] exp);
    logic [14:0] act;
    act = {fwd_a_e, fwd_b_e, en_f, en_d, en_e, en_m,
           flush_d, flush_e, flush_m, mdu_busy, mdu_done};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b required %b (fa fb enFDEM flDEM busy done)",
               name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    rst = 1'b0;
    rs1_d = '0; rs2_d = '0; use_rs1_d = 1'b0; use_rs2_d = 1'b0;
    rs1_e = '0; rs2_e = '0; rd_e = '0;
    ld_e = 1'b0; mdu_e = 1'b0; pc_sel_e = 1'b0;
    rd_m = '0; rd_w = '0; regwrite_m = 1'b0; regwrite_w = 1'b0;
    dmem_req_m = 1'b0; dmem_ready = 1'b1;
  endtask

  // Inputs are set just after a falling edge; outputs sampled 1 time unit
  // before the next rising edge.
  task automatic step_chk(string name, logic [14:0] exp);
    #4;
    check(name, exp);
    @(negedge clk);
  endtask

  // ---------------------------------------------------------------------
  // Table vectors (FSM idle, no MDU op, no reset)
  // ---------------------------------------------------------------------
  typedef struct {
    string             name;
    logic [REG_AW-1:0] rs1_d, rs2_d;
    logic              u1, u2;
    logic [REG_AW-1:0] rs1_e, rs2_e, rd_e;
    logic              ld, pcs;
    logic [REG_AW-1:0] rd_m, rd_w;
    logic              rwm, rww, dreq, drdy;
    logic [14:0]       exp;
  } vec_t;

  function automatic vec_t mkv(string n, int r1d, int r2d, bit u1, bit u2,
                               int r1e, int r2e, int rde, bit ld, bit pcs,
                               int rdm, int rdw, bit rwm, bit rww,
                               bit dreq, bit drdy, logic [14:0] exp);
    vec_t v;
    v.name = n;
    v.rs1_d = REG_AW'(r1d); v.rs2_d = REG_AW'(r2d); v.u1 = u1; v.u2 = u2;
    v.rs1_e = REG_AW'(r1e); v.rs2_e = REG_AW'(r2e); v.rd_e = REG_AW'(rde);
    v.ld = ld; v.pcs = pcs;
    v.rd_m = REG_AW'(rdm); v.rd_w = REG_AW'(rdw); v.rwm = rwm; v.rww = rww;
    v.dreq = dreq; v.drdy = drdy; v.exp = exp;
    return v;
  endfunction

  vec_t vecs[14];

  // ---------------------------------------------------------------------
  // Reference model: tracks how many EX occupancy cycles the current MDU
  // op still has, counting the present cycle.
  // ---------------------------------------------------------------------
  bit m_active;
  int m_left;

  function automatic logic [1:0] ref_fwd(logic [REG_AW-1:0] rs);
    if (rs == 0) return 2'b00;
    if (regwrite_m && rd_m == rs) return 2'b10;
    if (regwrite_w && rd_w == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic model_cycle(output logic [14:0] exp);
    bit memwait, lw, entering, in_op, hold, done;
    int cur_left;
    logic [3:0] en;
    logic [2:0] fl;
    if (rst) begin
      exp = ov(2'b00, 2'b00, EN_ALL, 3'b111, 1'b0, 1'b0);
      m_active = 1'b0;
      m_left = 0;
      return;
    end
    memwait  = dmem_req_m && !dmem_ready;
    lw       = ld_e && rd_e != 0 && ((use_rs1_d && rs1_d == rd_e) ||
                                     (use_rs2_d && rs2_d == rd_e));
    entering = !m_active && mdu_e && !memwait;
    in_op    = m_active || entering;
    cur_left = m_active ? m_left : MDU_LAT;
    hold     = in_op && cur_left > 1;
    done     = in_op && cur_left == 1 && !memwait;
    if (memwait)       begin en = EN_NONE; fl = 3'b000; end
    else if (hold)     begin en = EN_HOLD; fl = 3'b001; end
    else if (pc_sel_e) begin en = EN_ALL;  fl = 3'b110; end
    else if (lw)       begin en = EN_LW;   fl = 3'b010; end
    else               begin en = EN_ALL;  fl = 3'b000; end
    exp = ov(ref_fwd(rs1_e), ref_fwd(rs2_e), en, fl, in_op, done);
    if (!memwait && in_op) begin
      if (cur_left == 1) m_active = 1'b0;
      else begin
        m_active = 1'b1;
        m_left = cur_left - 1;
      end
    end
  endtask

  localparam logic [14:0] IDLE_OK  = 15'b00_00_1111_000_00;
  localparam logic [14:0] HOLD_OUT = 15'b00_00_0001_001_10;
  localparam logic [14:0] DONE_OUT = 15'b00_00_1111_000_11;
  localparam logic [14:0] WAIT_OUT = 15'b00_00_0000_000_10;
  localparam logic [14:0] RST_OUT  = 15'b00_00_1111_111_00;

  initial begin
    logic [14:0] exp;

    vecs[0]  = mkv("fwd_a_mem",   0,0,0,0, 5,0,0, 0,0, 5,5,1,1, 0,1, ov(2'b10,2'b00,EN_ALL,3'b000,0,0));
    vecs[1]  = mkv("fwd_a_wb",    0,0,0,0, 5,0,0, 0,0, 5,5,0,1, 0,1, ov(2'b01,2'b00,EN_ALL,3'b000,0,0));
    vecs[2]  = mkv("fwd_mix",     0,0,0,0, 5,6,0, 0,0, 6,5,1,1, 0,1, ov(2'b01,2'b10,EN_ALL,3'b000,0,0));
    vecs[3]  = mkv("fwd_x0",      0,0,0,0, 0,0,0, 0,0, 0,0,1,1, 0,1, ov(2'b00,2'b00,EN_ALL,3'b000,0,0));
    vecs[4]  = mkv("fwd_none",    0,0,0,0, 9,10,0,0,0, 5,5,1,1, 0,1, ov(2'b00,2'b00,EN_ALL,3'b000,0,0));
    vecs[5]  = mkv("lw_rs2",      0,7,0,1, 0,0,7, 1,0, 0,0,0,0, 0,1, ov(2'b00,2'b00,EN_LW,3'b010,0,0));
    vecs[6]  = mkv("lw_rs1",      3,0,1,0, 0,0,3, 1,0, 0,0,0,0, 0,1, ov(2'b00,2'b00,EN_LW,3'b010,0,0));
    vecs[7]  = mkv("lw_rd0",      0,0,0,1, 0,0,0, 1,0, 0,0,0,0, 0,1, ov(2'b00,2'b00,EN_ALL,3'b000,0,0));
    vecs[8]  = mkv("lw_unused",   0,7,0,0, 0,0,7, 1,0, 0,0,0,0, 0,1, ov(2'b00,2'b00,EN_ALL,3'b000,0,0));
    vecs[9]  = mkv("lw_notload",  0,7,0,1, 0,0,7, 0,0, 0,0,0,0, 0,1, ov(2'b00,2'b00,EN_ALL,3'b000,0,0));
    vecs[10] = mkv("br_lw",       0,7,0,1, 0,0,7, 1,1, 0,0,0,0, 0,1, ov(2'b00,2'b00,EN_ALL,3'b110,0,0));
    vecs[11] = mkv("br_only",     0,0,0,0, 0,0,0, 0,1, 0,0,0,0, 0,1, ov(2'b00,2'b00,EN_ALL,3'b110,0,0));
    vecs[12] = mkv("memwait_all", 0,7,0,1, 3,0,7, 1,1, 3,0,1,0, 1,0, ov(2'b10,2'b00,EN_NONE,3'b000,0,0));
    vecs[13] = mkv("dmem_ready",  0,7,0,1, 0,0,7, 1,0, 0,0,0,0, 1,1, ov(2'b00,2'b00,EN_LW,3'b010,0,0));

    clear_inputs();
    rst = 1'b1;
    @(negedge clk);
    step_chk("reset_0", RST_OUT);
    rst = 1'b1;
    rs1_e = 5; rd_m = 5; regwrite_m = 1'b1; mdu_e = 1'b1;
    step_chk("reset_fwd_gated", RST_OUT);
    clear_inputs();
    step_chk("post_reset_idle", IDLE_OK);

    for (int i = 0; i < 14; i++) begin
      rs1_d = vecs[i].rs1_d; rs2_d = vecs[i].rs2_d;
      use_rs1_d = vecs[i].u1; use_rs2_d = vecs[i].u2;
      rs1_e = vecs[i].rs1_e; rs2_e = vecs[i].rs2_e; rd_e = vecs[i].rd_e;
      ld_e = vecs[i].ld; pc_sel_e = vecs[i].pcs; mdu_e = 1'b0;
      rd_m = vecs[i].rd_m; rd_w = vecs[i].rd_w;
      regwrite_m = vecs[i].rwm; regwrite_w = vecs[i].rww;
      dmem_req_m = vecs[i].dreq; dmem_ready = vecs[i].drdy;
      step_chk(vecs[i].name, vecs[i].exp);
    end
    clear_inputs();
    step_chk("table_end_idle", IDLE_OK);

    // Plain MDU op: 3 hold cycles, done on the 4th, then idle.
    mdu_e = 1'b1;
    step_chk("mdu_c1", HOLD_OUT);
    step_chk("mdu_c2", HOLD_OUT);
    step_chk("mdu_c3", HOLD_OUT);
    step_chk("mdu_c4_done", DONE_OUT);
    mdu_e = 1'b0;
    step_chk("mdu_after", IDLE_OK);

    // Memory wait for 2 cycles mid-op: occupancy stretches to 6.
    mdu_e = 1'b1;
    step_chk("mw_c1", HOLD_OUT);
    step_chk("mw_c2", HOLD_OUT);
    dmem_req_m = 1'b1; dmem_ready = 1'b0;
    step_chk("mw_c3_wait", WAIT_OUT);
    step_chk("mw_c4_wait", WAIT_OUT);
    dmem_req_m = 1'b0; dmem_ready = 1'b1;
    step_chk("mw_c5", HOLD_OUT);
    step_chk("mw_c6_done", DONE_OUT);
    mdu_e = 1'b0;
    step_chk("mw_after", IDLE_OK);

    // Memory wait exactly on the final cycle delays the done pulse.
    mdu_e = 1'b1;
    step_chk("mwl_c1", HOLD_OUT);
    step_chk("mwl_c2", HOLD_OUT);
    step_chk("mwl_c3", HOLD_OUT);
    dmem_req_m = 1'b1; dmem_ready = 1'b0;
    step_chk("mwl_wait", WAIT_OUT);
    dmem_ready = 1'b1;
    step_chk("mwl_done", DONE_OUT);
    clear_inputs();

    // Reset mid-op: no done pulse, idle afterwards.
    mdu_e = 1'b1;
    step_chk("rb_c1", HOLD_OUT);
    step_chk("rb_c2", HOLD_OUT);
    rst = 1'b1;
    step_chk("rb_rst", RST_OUT);
    clear_inputs();
    step_chk("rb_after1", IDLE_OK);
    step_chk("rb_after2", IDLE_OK);

    // Back-to-back ops, with a redirect arriving alongside the second op.
    mdu_e = 1'b1;
    step_chk("bb1_c1", HOLD_OUT);
    step_chk("bb1_c2", HOLD_OUT);
    step_chk("bb1_c3", HOLD_OUT);
    step_chk("bb1_done", DONE_OUT);
    pc_sel_e = 1'b1;
    step_chk("bb2_c1", HOLD_OUT);
    step_chk("bb2_c2", HOLD_OUT);
    step_chk("bb2_c3", HOLD_OUT);
    step_chk("bb2_done_redirect", 15'b00_00_1111_110_11);
    clear_inputs();
    step_chk("bb_after", IDLE_OK);

    // Randomized run against the reference model.
    m_active = 1'b0;
    m_left = 0;
    for (int i = 0; i < 3000; i++) begin
      rst        = (i == 0) || ($urandom_range(0, 99) == 0);
      rs1_d      = REG_AW'($urandom_range(0, 7));
      rs2_d      = REG_AW'($urandom_range(0, 7));
      use_rs1_d  = 1'($urandom_range(0, 1));
      use_rs2_d  = 1'($urandom_range(0, 1));
      rs1_e      = REG_AW'($urandom_range(0, 7));
      rs2_e      = REG_AW'($urandom_range(0, 7));
      rd_e       = REG_AW'($urandom_range(0, 7));
      ld_e       = ($urandom_range(0, 2) == 0);
      mdu_e      = ($urandom_range(0, 3) == 0);
      pc_sel_e   = ($urandom_range(0, 7) == 0);
      rd_m       = REG_AW'($urandom_range(0, 7));
      rd_w       = REG_AW'($urandom_range(0, 7));
      regwrite_m = 1'($urandom_range(0, 1));
      regwrite_w = 1'($urandom_range(0, 1));
      dmem_req_m = 1'($urandom_range(0, 1));
      dmem_ready = ($urandom_range(0, 2) != 0);
      #4;
      model_cycle(exp);
      check("random", exp);
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
